// File: rtl/rv32_muldiv_unit_if.sv
// Request/response bundle between the execute stage and the iterative RV32M unit.
// The execute stage is the master; the multiply/divide unit is the slave.
interface rv32_muldiv_unit_if #(
  parameter int XLEN = 32
);
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      op;
  logic [XLEN-1:0] op1;
  logic [XLEN-1:0] op2;
  logic            busy;
  logic            out_valid;
  logic [XLEN-1:0] result;

  modport master (
    output flush, in_valid, op, op1, op2,
    input  in_ready, busy, out_valid, result
  );

  modport slave (
    input  flush, in_valid, op, op1, op2,
    output in_ready, busy, out_valid, result
  );
endinterface

// File: rtl/rv32_muldiv_unit.sv
// Iterative RV32M multiply/divide: radix-2^B shift-add multiply and restoring divide
// on operand magnitudes, with sign fix-up and single-cycle special-case bypass.
module rv32_muldiv_unit #(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic              clk,
  input  logic              resetn,
  rv32_muldiv_unit_if.slave bus
);
  localparam int B     = BITS_PER_CYCLE;
  localparam int N     = XLEN / B;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam int MW    = XLEN + B;

  if (!((B == 1) || (B == 2) || (B == 4)) || (XLEN % B != 0)) begin : g_param_check
    $error("rv32_muldiv_unit: BITS_PER_CYCLE must be 1, 2 or 4 and divide XLEN");
  end

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg;
  logic [2:0]        op_reg;
  logic              neg_q_reg, neg_r_reg;
  logic [XLEN-1:0]   hi_reg, lo_reg, den_reg, result_reg;

  logic              accept, op1_signed, op2_signed, sign1, sign2;
  logic              div_zero, div_ovf, special;
  logic [XLEN-1:0]   op1_mag, op2_mag, special_res;

  assign accept     = bus.in_valid && (state_reg == IDLE) && !bus.flush;
  assign op1_signed = (bus.op == 3'd1) || (bus.op == 3'd2) || (bus.op == 3'd4) || (bus.op == 3'd6);
  assign op2_signed = (bus.op == 3'd1) || (bus.op == 3'd4) || (bus.op == 3'd6);
  assign sign1      = op1_signed && bus.op1[XLEN-1];
  assign sign2      = op2_signed && bus.op2[XLEN-1];
  assign op1_mag    = sign1 ? -bus.op1 : bus.op1;
  assign op2_mag    = sign2 ? -bus.op2 : bus.op2;

  // Divide-by-zero and signed overflow have fixed answers and skip CALC/FIX.
  assign div_zero    = bus.op[2] && (bus.op2 == '0);
  assign div_ovf     = bus.op[2] && !bus.op[0] && (bus.op1 == {1'b1, {(XLEN-1){1'b0}}}) && (bus.op2 == '1);
  assign special     = div_zero || div_ovf;
  assign special_res = div_zero ? (bus.op[1] ? bus.op1 : '1) : (bus.op[1] ? '0 : bus.op1);

  // Multiply step: add multiplicand times the low B multiplier bits, shift right by B.
  logic [MW-1:0] mul_sum;
  assign mul_sum = MW'(hi_reg) + MW'(den_reg) * MW'(lo_reg[B-1:0]);

  // Divide step: B restoring iterations chained combinationally.
  logic [XLEN-1:0] div_hi, div_lo;
  logic [XLEN:0]   div_shift, div_diff;
  logic            div_fit;
  always_comb begin
    div_hi    = hi_reg;
    div_lo    = lo_reg;
    div_shift = '0;
    div_diff  = '0;
    div_fit   = 1'b0;
    for (int i = 0; i < B; i++) begin
      div_shift = {div_hi, div_lo[XLEN-1]};
      div_diff  = div_shift - {1'b0, den_reg};
      div_fit   = (div_shift >= {1'b0, den_reg});
      div_hi    = div_fit ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
      div_lo    = {div_lo[XLEN-2:0], div_fit};
    end
  end

  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, fix_res;
  assign prod_fix = neg_q_reg ? -{hi_reg, lo_reg} : {hi_reg, lo_reg};
  assign quo_fix  = neg_q_reg ? -lo_reg : lo_reg;
  assign rem_fix  = neg_r_reg ? -hi_reg : hi_reg;
  assign fix_res  = op_reg[2] ? (op_reg[1] ? rem_fix : quo_fix)
                  : ((op_reg[1:0] == 2'd0) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN]);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = special ? DONE : CALC;
      CALC:    if (cnt_reg == '0) state_next = FIX;
      FIX:     state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (bus.flush) state_next = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      op_reg     <= '0;
      neg_q_reg  <= 1'b0;
      neg_r_reg  <= 1'b0;
      hi_reg     <= '0;
      lo_reg     <= '0;
      den_reg    <= '0;
      result_reg <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: if (accept) begin
          op_reg    <= bus.op;
          neg_q_reg <= sign1 ^ sign2;
          neg_r_reg <= sign1;
          hi_reg    <= '0;
          lo_reg    <= op1_mag;
          den_reg   <= op2_mag;
          cnt_reg   <= CNT_W'(N - 1);
          if (special) result_reg <= special_res;
        end
        CALC: begin
          {hi_reg, lo_reg} <= op_reg[2] ? {div_hi, div_lo} : {mul_sum, lo_reg[XLEN-1:B]};
          if (cnt_reg != '0) cnt_reg <= cnt_reg - CNT_W'(1);
        end
        FIX: if (!bus.flush) result_reg <= fix_res;
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = resetn && (state_reg == IDLE);
  assign bus.busy      = (state_reg != IDLE);
  assign bus.out_valid = (state_reg == DONE);
  assign bus.result    = result_reg;
endmodule

// File: tb/tb_rv32_muldiv_unit.sv
// Bench for rv32_muldiv_unit: three instances (B = 1, 2, 4) checked against an
// arithmetic reference model; directed tests run on the B = 1 instance.
module tb_rv32_muldiv_unit;
  localparam int XLEN   = 32;
  localparam int NB     = 3;
  localparam int TARGET = 1000;
  localparam int BUDGET = 60000;
  localparam logic [31:0] MIN_INT = 32'h8000_0000;

  logic        clk;
  logic        resetn;
  logic        flush_a     [NB];
  logic        in_valid_a  [NB];
  logic [2:0]  op_a        [NB];
  logic [31:0] op1_a       [NB];
  logic [31:0] op2_a       [NB];
  logic        in_ready_a  [NB];
  logic        busy_a      [NB];
  logic        out_valid_a [NB];
  logic [31:0] result_a    [NB];

  int n_checks = 0;
  int n_fail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar gi = 0; gi < NB; gi++) begin : g_dut
    rv32_muldiv_unit_if #(.XLEN(XLEN)) bus ();
    assign bus.flush        = flush_a[gi];
    assign bus.in_valid     = in_valid_a[gi];
    assign bus.op           = op_a[gi];
    assign bus.op1          = op1_a[gi];
    assign bus.op2          = op2_a[gi];
    assign in_ready_a[gi]   = bus.in_ready;
    assign busy_a[gi]       = bus.busy;
    assign out_valid_a[gi]  = bus.out_valid;
    assign result_a[gi]     = bus.result;
    rv32_muldiv_unit #(.XLEN(XLEN), .BITS_PER_CYCLE(1 << gi)) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
    );
  end

  // Reference: RV32M semantics from plain 64-bit / signed 32-bit arithmetic.
  function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    logic signed [31:0] qa, qb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'h0, a});
    ub = longint'({32'h0, b});
    qa = a;
    qb = b;
    ref_model = '0;
    case (op)
      3'd0: begin p = ua * ub; ref_model = p[31:0];  end
      3'd1: begin p = sa * sb; ref_model = p[63:32]; end
      3'd2: begin p = sa * ub; ref_model = p[63:32]; end
      3'd3: begin p = ua * ub; ref_model = p[63:32]; end
      3'd4: ref_model = (b == 0) ? 32'hFFFF_FFFF : ((a == MIN_INT && b == 32'hFFFF_FFFF) ? a : 32'(qa / qb));
      3'd5: ref_model = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: ref_model = (b == 0) ? a : ((a == MIN_INT && b == 32'hFFFF_FFFF) ? 32'h0 : 32'(qa % qb));
      default: ref_model = (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    return op[2] && ((b == 0) || (!op[0] && a == MIN_INT && b == 32'hFFFF_FFFF));
  endfunction

  task automatic gen(input int k);
    int sel;
    sel      = int'($urandom_range(0, 9));
    op_a[k]  = 3'($urandom_range(0, 7));
    op1_a[k] = $urandom;
    op2_a[k] = $urandom;
    case (sel)
      0: op2_a[k] = 32'h0;
      1: begin op1_a[k] = MIN_INT; op2_a[k] = 32'hFFFF_FFFF; end
      2: op2_a[k] = 32'($urandom_range(1, 15));
      3: op2_a[k] = -32'($urandom_range(1, 15));
      4: op1_a[k] = 32'($urandom_range(0, 15));
      default: ;
    endcase
  endtask

  // Issue one op on the B=1 instance; lat counts cycles from the accept cycle to out_valid.
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output int lat);
    int w;
    op_a[0] = op; op1_a[0] = a; op2_a[0] = b; in_valid_a[0] = 1'b1;
    w = 0;
    while (!in_ready_a[0] && w < 100) begin @(posedge clk); #1; w++; end
    @(posedge clk); #1;
    in_valid_a[0] = 1'b0;
    lat = 1;
    while (!out_valid_a[0] && lat < 200) begin @(posedge clk); #1; lat++; end
    res = result_a[0];
    $display("op=%0d a=%h b=%h result=%h lat=%0d", op, a, b, res, lat);
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    for (int k = 0; k < NB; k++) begin
      flush_a[k] = 1'b0; in_valid_a[k] = 1'b1;
      op_a[k] = 3'd4; op1_a[k] = 32'd5; op2_a[k] = 32'd0;
    end
    repeat (3) begin @(posedge clk); #1; end
    for (int k = 0; k < NB; k++) begin
      n_checks++;
      if (in_ready_a[k] !== 1'b0 || busy_a[k] !== 1'b0 || out_valid_a[k] !== 1'b0 || result_a[k] !== 32'h0) begin
        n_fail++;
        $display("FAIL reset_state k=%0d: rdy=%b busy=%b ov=%b res=%h, required 0 0 0 00000000",
                 k, in_ready_a[k], busy_a[k], out_valid_a[k], result_a[k]);
      end
    end
    resetn = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < NB; k++) begin
      in_valid_a[k] = 1'b0;
      n_checks++;
      if (out_valid_a[k] !== 1'b1 || result_a[k] !== 32'hFFFF_FFFF) begin
        n_fail++;
        $display("FAIL first_accept k=%0d: ov=%b res=%h, required 1 ffffffff", k, out_valid_a[k], result_a[k]);
      end
    end
    @(posedge clk); #1;
    for (int k = 0; k < NB; k++) begin
      n_checks++;
      if (in_ready_a[k] !== 1'b1 || busy_a[k] !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_after_reset k=%0d: rdy=%b busy=%b, required 1 0", k, in_ready_a[k], busy_a[k]);
      end
    end
  endtask

  task automatic test_multiply();
    logic [2:0]  ops [4] = '{3'd0, 3'd1, 3'd2, 3'd3};
    logic [31:0] as  [4] = '{32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] bs  [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] exp [4] = '{32'hFFFF_FFEB, 32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    logic [31:0] res;
    int lat;
    for (int i = 0; i < 4; i++) begin
      do_op(ops[i], as[i], bs[i], res, lat);
      n_checks++;
      if (res !== exp[i]) begin n_fail++; $display("FAIL mul_result op=%0d: got %h, required %h", ops[i], res, exp[i]); end
      n_checks++;
      if (lat != 34) begin n_fail++; $display("FAIL mul_latency op=%0d: got %0d, required 34", ops[i], lat); end
    end
  endtask

  task automatic test_divide();
    logic [2:0]  ops [4] = '{3'd4, 3'd6, 3'd6, 3'd5};
    logic [31:0] as  [4] = '{32'd7, 32'd7, 32'hFFFF_FFF9, 32'hFFFF_FFFF};
    logic [31:0] bs  [4] = '{32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'd2, 32'd3};
    logic [31:0] exp [4] = '{32'hFFFF_FFFD, 32'h0000_0001, 32'hFFFF_FFFF, 32'h5555_5555};
    logic [31:0] res;
    int lat;
    for (int i = 0; i < 4; i++) begin
      do_op(ops[i], as[i], bs[i], res, lat);
      n_checks++;
      if (res !== exp[i]) begin n_fail++; $display("FAIL div_result op=%0d: got %h, required %h", ops[i], res, exp[i]); end
      n_checks++;
      if (lat != 34) begin n_fail++; $display("FAIL div_latency op=%0d: got %0d, required 34", ops[i], lat); end
    end
  endtask

  task automatic test_special();
    logic [2:0]  ops [4] = '{3'd4, 3'd7, 3'd4, 3'd6};
    logic [31:0] as  [4] = '{32'd5, 32'd5, MIN_INT, MIN_INT};
    logic [31:0] bs  [4] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] exp [4] = '{32'hFFFF_FFFF, 32'd5, MIN_INT, 32'h0};
    logic [31:0] res;
    int lat;
    for (int i = 0; i < 4; i++) begin
      do_op(ops[i], as[i], bs[i], res, lat);
      n_checks++;
      if (res !== exp[i]) begin n_fail++; $display("FAIL special_result op=%0d: got %h, required %h", ops[i], res, exp[i]); end
      n_checks++;
      if (lat != 1 || busy_a[0] !== 1'b1) begin
        n_fail++; $display("FAIL special_latency op=%0d: lat=%0d busy=%b, required 1 1", ops[i], lat, busy_a[0]);
      end
      @(posedge clk); #1;
      n_checks++;
      if (busy_a[0] !== 1'b0 || in_ready_a[0] !== 1'b1) begin
        n_fail++; $display("FAIL special_idle op=%0d: busy=%b rdy=%b, required 0 1", ops[i], busy_a[0], in_ready_a[0]);
      end
    end
  endtask

  task automatic test_flush();
    logic [31:0] res;
    int lat, w;
    bit seen_ov;
    do_op(3'd0, 32'd7, 32'hFFFF_FFFD, res, lat);
    @(posedge clk); #1;
    op_a[0] = 3'd4; op1_a[0] = 32'd100; op2_a[0] = 32'd7; in_valid_a[0] = 1'b1;
    w = 0;
    while (!in_ready_a[0] && w < 100) begin @(posedge clk); #1; w++; end
    @(posedge clk); #1;
    in_valid_a[0] = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    n_checks++;
    if (busy_a[0] !== 1'b1) begin n_fail++; $display("FAIL flush_busy_before: got %b, required 1", busy_a[0]); end
    flush_a[0] = 1'b1;
    @(posedge clk); #1;
    flush_a[0] = 1'b0;
    n_checks++;
    if (busy_a[0] !== 1'b0 || in_ready_a[0] !== 1'b1 || out_valid_a[0] !== 1'b0) begin
      n_fail++; $display("FAIL flush_to_idle: busy=%b rdy=%b ov=%b, required 0 1 0", busy_a[0], in_ready_a[0], out_valid_a[0]);
    end
    seen_ov = 0;
    repeat (40) begin @(posedge clk); #1; if (out_valid_a[0]) seen_ov = 1; end
    n_checks++;
    if (seen_ov || result_a[0] !== 32'hFFFF_FFEB) begin
      n_fail++; $display("FAIL flush_no_result: ov_seen=%0d res=%h, required 0 ffffffeb", seen_ov, result_a[0]);
    end
    $display("flush DIV 100/7 at CALC cycle 10 result=%h", result_a[0]);
    op_a[0] = 3'd4; op1_a[0] = 32'd5; op2_a[0] = 32'd0;
    in_valid_a[0] = 1'b1; flush_a[0] = 1'b1;
    @(posedge clk); #1;
    in_valid_a[0] = 1'b0; flush_a[0] = 1'b0;
    n_checks++;
    if (busy_a[0] !== 1'b0 || out_valid_a[0] !== 1'b0) begin
      n_fail++; $display("FAIL flush_blocks_accept: busy=%b ov=%b, required 0 0", busy_a[0], out_valid_a[0]);
    end
    @(posedge clk); #1;
    n_checks++;
    if (out_valid_a[0] !== 1'b0 || result_a[0] !== 32'hFFFF_FFEB) begin
      n_fail++; $display("FAIL flush_accept_result: ov=%b res=%h, required 0 ffffffeb", out_valid_a[0], result_a[0]);
    end
    $display("flush with in_valid in IDLE result=%h", result_a[0]);
  endtask

  task automatic test_back_to_back();
    int          c;
    bit          all_done;
    int          issued   [NB];
    int          done     [NB];
    bit          pend     [NB];
    logic [31:0] pend_res [NB];
    int          pend_cyc [NB];
    int          pend_lat [NB];
    int          last_acc [NB];
    int          last_gap [NB];
    bit          prev_ov  [NB];
    bit          acc_now  [NB];
    for (int k = 0; k < NB; k++) begin
      issued[k] = 0; done[k] = 0; pend[k] = 0; last_acc[k] = -1; last_gap[k] = 0;
      prev_ov[k] = 0; acc_now[k] = 0; pend_res[k] = '0; pend_cyc[k] = 0; pend_lat[k] = 0;
      gen(k);
      in_valid_a[k] = 1'b1;
    end
    c = 0;
    all_done = 0;
    while (c < BUDGET && !all_done) begin
      for (int k = 0; k < NB; k++) begin
        if (out_valid_a[k]) begin
          n_checks++;
          if (prev_ov[k]) begin n_fail++; $display("FAIL b2b_double_valid k=%0d cycle=%0d: out_valid high twice, required once", k, c); end
          n_checks++;
          if (!pend[k] || result_a[k] !== pend_res[k]) begin
            n_fail++; $display("FAIL b2b_result k=%0d: got %h, required %h (pending=%0d)", k, result_a[k], pend_res[k], pend[k]);
          end
          n_checks++;
          if (c - pend_cyc[k] != pend_lat[k]) begin
            n_fail++; $display("FAIL b2b_latency k=%0d: got %0d, required %0d", k, c - pend_cyc[k], pend_lat[k]);
          end
          $display("B=%0d #%0d result=%h expected=%h", 1 << k, done[k], result_a[k], pend_res[k]);
          pend[k] = 0;
          done[k]++;
        end
        prev_ov[k] = out_valid_a[k];
        acc_now[k] = in_valid_a[k] && in_ready_a[k];
        if (acc_now[k]) begin
          if (last_acc[k] >= 0) begin
            n_checks++;
            if (c - last_acc[k] != last_gap[k]) begin
              n_fail++; $display("FAIL b2b_spacing k=%0d: got %0d, required %0d", k, c - last_acc[k], last_gap[k]);
            end
          end
          pend[k]     = 1;
          pend_res[k] = ref_model(op_a[k], op1_a[k], op2_a[k]);
          pend_lat[k] = is_special(op_a[k], op1_a[k], op2_a[k]) ? 1 : (XLEN >> k) + 2;
          pend_cyc[k] = c;
          last_acc[k] = c;
          last_gap[k] = pend_lat[k] + 1;
          issued[k]++;
        end
      end
      @(posedge clk); #1;
      c++;
      all_done = 1;
      for (int k = 0; k < NB; k++) begin
        if (acc_now[k]) begin
          if (issued[k] < TARGET) gen(k);
          else in_valid_a[k] = 1'b0;
        end
        if (done[k] < TARGET) all_done = 0;
      end
    end
    for (int k = 0; k < NB; k++) begin
      in_valid_a[k] = 1'b0;
      n_checks++;
      if (done[k] != TARGET) begin n_fail++; $display("FAIL b2b_completed k=%0d: got %0d, required %0d", k, done[k], TARGET); end
    end
  endtask

  initial begin
    test_reset();
    test_multiply();
    test_divide();
    test_special();
    test_flush();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
